// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: register file writeback arbiter with ALU port A and round-robin LSU/MUL port B.
// Define RISCV_WB_SCOREBOARD_EN to build the per-register pending-write scoreboard on busy_o.
module riscv_wb_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    always_comb begin
        wr_d  = push_i ? wr_q + PW'(1) : wr_q;
        rd_d  = pop_i ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem[wr_q] <= addr_i;
            data_mem[wr_q] <= data_i;
        end
    end
    assign full_o      = cnt_q == (PW+1)'(DEPTH);
    assign empty_o     = cnt_q == '0;
    assign head_addr_o = addr_mem[rd_q];
    assign head_data_o = data_mem[rd_q];
endmodule

module riscv_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_we_i,
    input  logic [ADDR_WIDTH-1:0]    alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    alu_wdata_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
    input  logic                     mul_valid_i,
    output logic                     mul_ready_o,
    input  logic [ADDR_WIDTH-1:0]    mul_waddr_i,
    input  logic [DATA_WIDTH-1:0]    mul_wdata_i,
    input  logic                     rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]    rsv_addr_i,
    output logic                     we_a_o,
    output logic [ADDR_WIDTH-1:0]    waddr_a_o,
    output logic [DATA_WIDTH-1:0]    wdata_a_o,
    output logic                     we_b_o,
    output logic [ADDR_WIDTH-1:0]    waddr_b_o,
    output logic [DATA_WIDTH-1:0]    wdata_b_o,
    output logic [2**ADDR_WIDTH-1:0] busy_o
);
    typedef enum logic {SRC_LSU, SRC_MUL} src_e;
    src_e                  rr_q, rr_d;
    logic                  we_a_q, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q, wdata_b_d;
    logic                  lsu_full, lsu_empty, mul_full, mul_empty;
    logic [ADDR_WIDTH-1:0] lsu_head_addr, mul_head_addr, b_addr;
    logic [DATA_WIDTH-1:0] lsu_head_data, mul_head_data;
    logic                  lsu_elig, mul_elig, gnt_lsu, gnt_mul;

    assign lsu_ready_o = !lsu_full;
    assign mul_ready_o = !mul_full;

    riscv_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk(clk), .rst(rst), .push_i(lsu_valid_i && lsu_ready_o), .addr_i(lsu_waddr_i),
        .data_i(lsu_wdata_i), .pop_i(gnt_lsu), .full_o(lsu_full), .empty_o(lsu_empty),
        .head_addr_o(lsu_head_addr), .head_data_o(lsu_head_data)
    );
    riscv_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk(clk), .rst(rst), .push_i(mul_valid_i && mul_ready_o), .addr_i(mul_waddr_i),
        .data_i(mul_wdata_i), .pop_i(gnt_mul), .full_o(mul_full), .empty_o(mul_empty),
        .head_addr_o(mul_head_addr), .head_data_o(mul_head_data)
    );

    // A head aimed at the register the ALU is writing this cycle waits, so ports A and B never collide.
    always_comb begin
        lsu_elig  = !lsu_empty && !(alu_we_i && alu_waddr_i == lsu_head_addr);
        mul_elig  = !mul_empty && !(alu_we_i && alu_waddr_i == mul_head_addr);
        gnt_lsu   = lsu_elig && (!mul_elig || rr_q == SRC_LSU);
        gnt_mul   = mul_elig && !gnt_lsu;
        rr_d      = gnt_lsu ? SRC_MUL : gnt_mul ? SRC_LSU : rr_q;
        b_addr    = gnt_lsu ? lsu_head_addr : mul_head_addr;
        we_b_d    = (gnt_lsu || gnt_mul) && b_addr != '0;
        waddr_b_d = (gnt_lsu || gnt_mul) ? b_addr : waddr_b_q;
        wdata_b_d = gnt_lsu ? lsu_head_data : gnt_mul ? mul_head_data : wdata_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= SRC_LSU;
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            rr_q      <= rr_d;
            we_a_q    <= alu_we_i && alu_waddr_i != '0;
            waddr_a_q <= alu_waddr_i;
            wdata_a_q <= alu_wdata_i;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;

`ifdef RISCV_WB_SCOREBOARD_EN
    logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
    // Reservation applied after the clear so a coincident set wins.
    always_comb begin
        busy_d = busy_q;
        if (we_b_d) busy_d[waddr_b_d] = 1'b0;
        if (rsv_valid_i && rsv_addr_i != '0) busy_d[rsv_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end
    assign busy_o = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid_i, rsv_addr_i};
    assign busy_o = '0;
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed self-checking bench for riscv_wb_arbiter with default parameters.
module tb_riscv_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_we_i = 1'b0;
    logic [4:0]  alu_waddr_i = '0;
    logic [31:0] alu_wdata_i = '0;
    logic        lsu_valid_i = 1'b0, lsu_ready_o;
    logic [4:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        mul_valid_i = 1'b0, mul_ready_o;
    logic [4:0]  mul_waddr_i = '0;
    logic [31:0] mul_wdata_i = '0;
    logic        rsv_valid_i = 1'b0;
    logic [4:0]  rsv_addr_i = '0;
    logic        we_a_o, we_b_o;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o, busy_o;
    int          n_checks = 0;
    int          n_fail = 0;

    riscv_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o), .mul_waddr_i(mul_waddr_i), .mul_wdata_i(mul_wdata_i),
        .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_we_a", we_a_o, 0);
        check("rst_we_b", we_b_o, 0);
        check("rst_waddr_a", waddr_a_o, 0);
        check("rst_wdata_a", wdata_a_o, 0);
        check("rst_waddr_b", waddr_b_o, 0);
        check("rst_wdata_b", wdata_b_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b0;
        tick();
        check("rst_lsu_ready", lsu_ready_o, 1);
        check("rst_mul_ready", mul_ready_o, 1);

        alu_we_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'hDEADBEEF;
        tick();
        check("alu_we", we_a_o, 1);
        check("alu_waddr", waddr_a_o, 5);
        check("alu_wdata", wdata_a_o, 32'hDEADBEEF);
        alu_waddr_i = 5'd0; alu_wdata_i = 32'h1;
        tick();
        check("alu_x0_we", we_a_o, 0);
        check("alu_x0_wdata", wdata_a_o, 1);
        alu_we_i = 1'b0;
        tick();
        check("alu_idle_we", we_a_o, 0);

        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd3; lsu_wdata_i = 32'hAAAA0003;
        mul_valid_i = 1'b1; mul_waddr_i = 5'd7; mul_wdata_i = 32'hBBBB0007;
        tick();
        check("rr_first_idle", we_b_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_we", we_b_o, 1);
            check("rr_addr", waddr_b_o, (i % 2 == 0) ? 3 : 7);
            check("rr_data", wdata_b_o, (i % 2 == 0) ? 32'hAAAA0003 : 32'hBBBB0007);
        end
        lsu_valid_i = 1'b0; mul_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("drain_we", we_b_o, 0);

        alu_we_i = 1'b1; alu_waddr_i = 5'd9; alu_wdata_i = 32'h0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h11;
        tick();
        lsu_wdata_i = 32'h22;
        tick();
        check("bp_full_ready", lsu_ready_o, 0);
        check("bp_blocked_we", we_b_o, 0);
        lsu_wdata_i = 32'h33;
        tick();
        check("bp_held_ready", lsu_ready_o, 0);
        check("coll_we", we_b_o, 0);
        alu_we_i = 1'b0;
        tick();
        check("retry_we", we_b_o, 1);
        check("retry_addr", waddr_b_o, 9);
        check("ord_1", wdata_b_o, 32'h11);
        check("bp_ready_again", lsu_ready_o, 1);
        tick();
        check("ord_2", wdata_b_o, 32'h22);
        lsu_valid_i = 1'b0;
        tick();
        check("ord_3_we", we_b_o, 1);
        check("ord_3", wdata_b_o, 32'h33);
        tick();
        check("hold_we", we_b_o, 0);
        check("hold_addr", waddr_b_o, 9);
        check("hold_data", wdata_b_o, 32'h33);

        mul_valid_i = 1'b1; mul_waddr_i = 5'd0; mul_wdata_i = 32'h55;
        tick();
        mul_waddr_i = 5'd7; mul_wdata_i = 32'h77;
        tick();
        mul_valid_i = 1'b0;
        check("x0_discard_we", we_b_o, 0);
        tick();
        check("after_x0_we", we_b_o, 1);
        check("after_x0_data", wdata_b_o, 32'h77);

        alu_we_i = 1'b1; alu_waddr_i = 5'd9;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'hA1;
        mul_valid_i = 1'b1; mul_waddr_i = 5'd9; mul_wdata_i = 32'hB1;
        tick();
        tick();
        check("full_lsu_ready", lsu_ready_o, 0);
        check("full_mul_ready", mul_ready_o, 0);
        rst = 1'b1; alu_we_i = 1'b0; lsu_valid_i = 1'b0; mul_valid_i = 1'b0;
        tick();
        check("mrst_we_b", we_b_o, 0);
        check("mrst_lsu_ready", lsu_ready_o, 1);
        check("mrst_mul_ready", mul_ready_o, 1);
        check("mrst_busy", busy_o, 0);
        rst = 1'b0;
        tick();
        check("mrst_after_we_b", we_b_o, 0);
        tick();
        check("mrst_no_stale_we_b", we_b_o, 0);

`ifdef RISCV_WB_SCOREBOARD_EN
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd12;
        tick();
        rsv_valid_i = 1'b0;
        check("sb_set", busy_o, 32'h0000_1000);
        mul_valid_i = 1'b1; mul_waddr_i = 5'd12; mul_wdata_i = 32'hC;
        tick();
        mul_valid_i = 1'b0;
        tick();
        check("sb_write_we", we_b_o, 1);
        check("sb_clear", busy_o, 0);
        rsv_valid_i = 1'b1;
        tick();
        rsv_valid_i = 1'b0;
        mul_valid_i = 1'b1;
        tick();
        mul_valid_i = 1'b0;
        rsv_valid_i = 1'b1;
        tick();
        rsv_valid_i = 1'b0;
        check("sb_coinc_we", we_b_o, 1);
        check("sb_coinc_keep", busy_o, 32'h0000_1000);
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd0;
        tick();
        rsv_valid_i = 1'b0;
        check("sb_x0", busy_o, 32'h0000_1000);
`else
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd12;
        tick();
        rsv_valid_i = 1'b0;
        check("sb_off", busy_o, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
